// File: rtl/tx_cfg_sequencer.sv
// TX DSP configuration sequencer: ramps mixer gain to zero around LO/PD retunes
// and ramps to the requested gain afterwards, one request at a time.
module tx_cfg_sequencer #(
  parameter int unsigned GAIN_STEP       = 1,
  parameter int unsigned STEP_INTERVAL   = 4,
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter logic [15:0] RESET_PHASE_INC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_gain,
  input  logic [15:0] cfg_phase_inc,
  input  logic        cfg_pre_distortion,
  output logic [7:0]  mixer_gain,
  output logic [15:0] lo_dds_phase_inc,
  output logic        enable_pre_distortion,
  output logic        busy,
  output logic        update_done
);

  localparam int CW = 16;
  localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_INTERVAL - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    STEP        = 8'(GAIN_STEP);

  typedef enum logic [2:0] {IDLE, RAMP_DOWN, APPLY, SETTLE, RAMP_UP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    gain_nxt, sh_gain, sh_gain_nxt, goal, stepped;
  logic [15:0]   phase_nxt, sh_phase, sh_phase_nxt;
  logic          pd_nxt, sh_pd, sh_pd_nxt, done_nxt;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign goal      = (state == RAMP_DOWN) ? 8'd0 : sh_gain;

  // Clamp to goal when within one step, so the ramp never overshoots or wraps.
  always_comb begin
    stepped = mixer_gain;
    if (goal > mixer_gain)
      stepped = ((goal - mixer_gain) <= STEP) ? goal : mixer_gain + STEP;
    else
      stepped = ((mixer_gain - goal) <= STEP) ? goal : mixer_gain - STEP;
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    gain_nxt     = mixer_gain;
    phase_nxt    = lo_dds_phase_inc;
    pd_nxt       = enable_pre_distortion;
    sh_gain_nxt  = sh_gain;
    sh_phase_nxt = sh_phase;
    sh_pd_nxt    = sh_pd;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          sh_gain_nxt  = cfg_gain;
          sh_phase_nxt = cfg_phase_inc;
          sh_pd_nxt    = cfg_pre_distortion;
          cnt_nxt      = '0;
          if ((cfg_phase_inc != lo_dds_phase_inc) || (cfg_pre_distortion != enable_pre_distortion))
            state_nxt = RAMP_DOWN;
          else
            state_nxt = RAMP_UP;
        end
      end
      RAMP_DOWN, RAMP_UP: begin
        if (mixer_gain == goal) begin
          if (state == RAMP_DOWN) begin
            state_nxt = APPLY;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else if (cnt == STEP_LAST) begin
          gain_nxt = stepped;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      APPLY: begin
        phase_nxt = sh_phase;
        pd_nxt    = sh_pd;
        cnt_nxt   = '0;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = RAMP_UP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= IDLE;
      cnt                   <= '0;
      mixer_gain            <= '0;
      lo_dds_phase_inc      <= RESET_PHASE_INC;
      enable_pre_distortion <= 1'b0;
      sh_gain               <= '0;
      sh_phase              <= '0;
      sh_pd                 <= 1'b0;
      update_done           <= 1'b0;
    end else begin
      state                 <= state_nxt;
      cnt                   <= cnt_nxt;
      mixer_gain            <= gain_nxt;
      lo_dds_phase_inc      <= phase_nxt;
      enable_pre_distortion <= pd_nxt;
      sh_gain               <= sh_gain_nxt;
      sh_phase              <= sh_phase_nxt;
      sh_pd                 <= sh_pd_nxt;
      update_done           <= done_nxt;
    end
  end

endmodule

// File: tb/tb_tx_cfg_sequencer.sv
// Directed bench for tx_cfg_sequencer: default instance plus a GAIN_STEP=8 instance.
module tb_tx_cfg_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_gain;
  logic [15:0] cfg_phase_inc;
  logic        cfg_pre_distortion;
  logic [7:0]  mixer_gain;
  logic [15:0] lo_dds_phase_inc;
  logic        enable_pre_distortion;
  logic        busy;
  logic        update_done;

  logic        v8;
  logic        ready8;
  logic [7:0]  g8;
  logic [15:0] p8 = 16'h0000;
  logic        pd8 = 1'b0;
  logic [7:0]  gain8;
  logic [15:0] phase8;
  logic        pdo8;
  logic        busy8;
  logic        done8;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  tx_cfg_sequencer u_dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_gain(cfg_gain), .cfg_phase_inc(cfg_phase_inc), .cfg_pre_distortion(cfg_pre_distortion),
    .mixer_gain(mixer_gain), .lo_dds_phase_inc(lo_dds_phase_inc),
    .enable_pre_distortion(enable_pre_distortion), .busy(busy), .update_done(update_done)
  );

  tx_cfg_sequencer #(.GAIN_STEP(8)) u_dut8 (
    .clock(clock), .reset(reset), .cfg_valid(v8), .cfg_ready(ready8),
    .cfg_gain(g8), .cfg_phase_inc(p8), .cfg_pre_distortion(pd8),
    .mixer_gain(gain8), .lo_dds_phase_inc(phase8),
    .enable_pre_distortion(pdo8), .busy(busy8), .update_done(done8)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_gain = '0; cfg_phase_inc = '0; cfg_pre_distortion = 1'b0;
    v8 = 1'b0; g8 = '0;
    tick(2);
    reset = 1'b0;
    chk("rst_gain", mixer_gain, 0);
    chk("rst_phase", lo_dds_phase_inc, 16'h0000);
    chk("rst_pd", enable_pre_distortion, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_done", update_done, 0);

    // Gain-only 0 -> 3, accepted at cycle T
    cfg_valid = 1; cfg_gain = 8'd3; cfg_phase_inc = 16'h0000; cfg_pre_distortion = 0;
    tick(); cfg_valid = 0;                       // T+1
    chk("g1_busy", busy, 1);
    chk("g1_ready", cfg_ready, 0);
    tick(3); chk("g1_t4", mixer_gain, 0);
    tick();  chk("g1_t5", mixer_gain, 1);
    tick(3); chk("g1_t8", mixer_gain, 1);
    tick();  chk("g1_t9", mixer_gain, 2);
    tick(4); chk("g1_t13", mixer_gain, 3);
    chk("g1_t13_done", update_done, 0);
    tick();  chk("g1_done", update_done, 1);     // T+14
    chk("g1_busy_lo", busy, 0);
    chk("g1_ready_hi", cfg_ready, 1);
    tick();  chk("g1_done_lo", update_done, 0);  // T+15

    // Retune: gain 3 -> 0, apply phase 1234 / PD 1, settle, ramp to 2
    cfg_valid = 1; cfg_gain = 8'd2; cfg_phase_inc = 16'h1234; cfg_pre_distortion = 1;
    tick(); cfg_valid = 0;                       // T+1
    chk("rt_busy", busy, 1);
    tick(4); chk("rt_t5", mixer_gain, 2);
    tick(8); chk("rt_t13", mixer_gain, 0);
    chk("rt_t13_phase", lo_dds_phase_inc, 16'h0000);
    tick();  chk("rt_apply_phase", lo_dds_phase_inc, 16'h0000); // T+14 APPLY
    tick();  chk("rt_t15_phase", lo_dds_phase_inc, 16'h1234);
    chk("rt_t15_pd", enable_pre_distortion, 1);
    chk("rt_t15_gain", mixer_gain, 0);
    tick(19); chk("rt_t34_gain", mixer_gain, 0);
    chk("rt_t34_busy", busy, 1);
    tick();  chk("rt_t35_gain", mixer_gain, 1);
    tick(4); chk("rt_t39_gain", mixer_gain, 2);
    chk("rt_t39_done", update_done, 0);
    tick();  chk("rt_done", update_done, 1);     // T+40
    chk("rt_busy_lo", busy, 0);

    // Gain-only 2 -> 4 with valid held high carrying a second request
    tick();
    cfg_valid = 1; cfg_gain = 8'd4; cfg_phase_inc = 16'h1234; cfg_pre_distortion = 1;
    tick();                                      // A+1
    cfg_gain = 8'd1;
    chk("hold_ready", cfg_ready, 0);
    tick(4); chk("hold_a5", mixer_gain, 3);
    tick(4); chk("hold_a9", mixer_gain, 4);
    chk("hold_a9_ready", cfg_ready, 0);
    tick();  chk("hold_done", update_done, 1);   // A+10, second request accepted here
    chk("hold_ready_hi", cfg_ready, 1);
    tick(); cfg_valid = 0;                       // A+11
    chk("hold_busy2", busy, 1);
    chk("hold_done_lo", update_done, 0);
    tick(4); chk("down_a15", mixer_gain, 3);
    tick(8); chk("down_a23", mixer_gain, 1);
    chk("down_phase", lo_dds_phase_inc, 16'h1234);
    tick();  chk("down_done", update_done, 1);   // A+24
    chk("down_busy_lo", busy, 0);

    // Request identical to current settings
    tick();
    cfg_valid = 1; cfg_gain = 8'd1; cfg_phase_inc = 16'h1234; cfg_pre_distortion = 1;
    tick(); cfg_valid = 0;                       // B+1
    chk("same_busy", busy, 1);
    chk("same_ready", cfg_ready, 0);
    chk("same_done_early", update_done, 0);
    tick();                                      // B+2
    chk("same_done", update_done, 1);
    chk("same_busy_lo", busy, 0);
    chk("same_gain", mixer_gain, 1);
    chk("same_phase", lo_dds_phase_inc, 16'h1234);
    chk("same_pd", enable_pre_distortion, 1);
    tick();  chk("same_done_lo", update_done, 0);

    // Reset during SETTLE
    cfg_valid = 1; cfg_gain = 8'd0; cfg_phase_inc = 16'h0055; cfg_pre_distortion = 0;
    tick(); cfg_valid = 0;                       // C+1
    tick(4); chk("rs_c5_gain", mixer_gain, 0);
    tick(2); chk("rs_c7_phase", lo_dds_phase_inc, 16'h0055);
    tick(3); chk("rs_c10_busy", busy, 1);        // C+10 in SETTLE
    reset = 1;
    tick();
    chk("rs_gain", mixer_gain, 0);
    chk("rs_phase", lo_dds_phase_inc, 16'h0000);
    chk("rs_pd", enable_pre_distortion, 0);
    chk("rs_busy", busy, 0);
    chk("rs_ready", cfg_ready, 1);
    chk("rs_done", update_done, 0);
    reset = 0;
    tick();
    chk("rs_done_after", update_done, 0);
    chk("rs_ready_after", cfg_ready, 1);

    // GAIN_STEP=8 instance: 0 -> 20 clamped, then 20 -> 5 without wrap
    v8 = 1; g8 = 8'd20;
    tick(); v8 = 0;
    tick(4); chk("s8_t5", gain8, 8);
    tick(4); chk("s8_t9", gain8, 16);
    tick(4); chk("s8_t13", gain8, 20);
    tick();  chk("s8_done", done8, 1);
    tick();
    v8 = 1; g8 = 8'd5;
    tick(); v8 = 0;
    tick(4); chk("s8_d5", gain8, 12);
    tick(4); chk("s8_d9", gain8, 5);
    tick();  chk("s8_d10_done", done8, 1);
    chk("s8_final", gain8, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
